// File: rtl/trng_arbiter.sv
// trng_arbiter: round-robin scheduler sharing one 256-bit TRNG core among N requesters.
// Each grant kicks the core, waits for its rdy handshake, then streams all eight words.
module trng_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64,
  parameter int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [31:0]    dout,
  output logic           dout_valid,
  output logic           dout_last,
  output logic [IDW-1:0] dout_id,
  output logic           err,
  output logic           busy,
  output logic           trng_en,
  output logic           trng_rd_en,
  output logic [2:0]     trng_addr,
  input  logic [31:0]    trng_out,
  input  logic           trng_rdy
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    WAIT_LOW,
    WAIT_HIGH,
    READ,
    DONE
  } state_t;

  state_t         state_q;
  logic [N-1:0]   gnt_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] dout_id_q;
  logic [WDW-1:0] wdog_q;
  logic           trng_en_q;
  logic           trng_rd_en_q;
  logic [2:0]     trng_addr_q;
  logic           dout_valid_q;
  logic           dout_last_q;
  logic           err_q;

  logic [IDW-1:0] winner_d;
  logic [IDW-1:0] idx_d;
  logic [N-1:0]   onehot_d;

  // Search upward from pointer+1 with wrap; the descending loop lets the nearest requester win
  always_comb begin
    winner_d = ptr_q;
    idx_d    = '0;
    for (int i = N; i >= 1; i--) begin
      idx_d = IDW'((int'(ptr_q) + i) % N);
      if (req[idx_d]) begin
        winner_d = idx_d;
      end
    end
  end

  assign onehot_d = {{(N-1){1'b0}}, 1'b1} << winner_d;

  // Main control FSM: grant, kick the core, guard the handshake with a watchdog, read eight words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      ptr_q        <= IDW'(N - 1);
      dout_id_q    <= '0;
      wdog_q       <= '0;
      trng_en_q    <= 1'b0;
      trng_rd_en_q <= 1'b0;
      trng_addr_q  <= 3'd0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      trng_en_q    <= 1'b0;
      err_q        <= 1'b0;
      dout_valid_q <= trng_rd_en_q;
      dout_last_q  <= trng_rd_en_q && (trng_addr_q == 3'd7);
      case (state_q)
        IDLE: begin
          if ((|req) && trng_rdy) begin
            gnt_q     <= onehot_d;
            dout_id_q <= winner_d;
            ptr_q     <= winner_d;
            trng_en_q <= 1'b1;
            state_q   <= KICK;
          end
        end
        KICK: begin
          wdog_q  <= WDW'(1);
          state_q <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (wdog_q == WDW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            gnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            wdog_q <= wdog_q + WDW'(1);
            if (!trng_rdy) begin
              state_q <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (trng_rdy) begin
            trng_rd_en_q <= 1'b1;
            trng_addr_q  <= 3'd0;
            state_q      <= READ;
          end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            gnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            wdog_q <= wdog_q + WDW'(1);
          end
        end
        READ: begin
          if (trng_addr_q == 3'd7) begin
            trng_rd_en_q <= 1'b0;
            trng_addr_q  <= 3'd0;
            state_q      <= DONE;
          end else begin
            trng_addr_q <= trng_addr_q + 3'd1;
          end
        end
        DONE: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign dout       = trng_out;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign dout_id    = dout_id_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);
  assign trng_en    = trng_en_q;
  assign trng_rd_en = trng_rd_en_q;
  assign trng_addr  = trng_addr_q;

endmodule

// File: tb/tb_trng_arbiter.sv
// tb_trng_arbiter: behavioural TRNG core, transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_trng_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 64;
  localparam int IDW     = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [31:0]    dout;
  logic           dout_valid;
  logic           dout_last;
  logic [IDW-1:0] dout_id;
  logic           err;
  logic           busy;
  logic           trng_en;
  logic           trng_rd_en;
  logic [2:0]     trng_addr;
  logic [31:0]    trng_out;
  logic           trng_rdy;

  int checks = 0;
  int errors = 0;

  trng_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_id    (dout_id),
    .err        (err),
    .busy       (busy),
    .trng_en    (trng_en),
    .trng_rd_en (trng_rd_en),
    .trng_addr  (trng_addr),
    .trng_out   (trng_out),
    .trng_rdy   (trng_rdy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Core model: mode 0 finishes 22 cycles after rdy drops, mode 1 never finishes, mode 2 ignores start
  int          coreMode;
  int          coreCnt;
  logic [31:0] coreWords [8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trng_rdy <= 1'b1;
      coreCnt  <= 0;
      trng_out <= '0;
    end else begin
      if (trng_en && coreMode != 2) begin
        trng_rdy <= 1'b0;
        coreCnt  <= (coreMode == 0) ? 22 : 0;
        for (int i = 0; i < 8; i++) coreWords[3'(i)] <= $urandom;
      end else if (!trng_rdy && coreMode == 0) begin
        if (coreCnt <= 1) begin
          trng_rdy <= 1'b1;
          coreCnt  <= 0;
        end else begin
          coreCnt <= coreCnt - 1;
        end
      end
      if (trng_rd_en) trng_out <= coreWords[trng_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: one transaction record with kick cycle, rdy-rise cycle and captured words
  bit          mAct;
  int          mKick, mRise, mSawLow, mId, mPtr;
  logic [31:0] mWords [8];

  always @(negedge clk) begin : compare
    bit           actNow, expEn, expErr, expRd, expVal, idleNow;
    int           k, idx, win;
    logic [N-1:0] expGnt;
    logic [IDW-1:0] sel;
    if (!rst_n) begin
      mAct = 1'b0; mPtr = N - 1; mRise = -1; mSawLow = -1; mKick = -1; mId = 0;
      checkOutput("reset_outputs",
                  32'({gnt, dout_valid, dout_last, dout_id, err, busy, trng_en, trng_rd_en, trng_addr, (dout != 32'd0)}),
                  32'd0);
    end else begin
      actNow = mAct && (cyc >= mKick) && ((mRise >= 0) ? (cyc <= mRise + 9) : (cyc < mKick + TIMEOUT));
      expGnt = actNow ? (N'(1) << mId) : '0;
      expEn  = actNow && (cyc == mKick);
      expErr = mAct && (mRise < 0) && (cyc == mKick + TIMEOUT);
      expRd  = mAct && (mRise >= 0) && (cyc >= mRise + 1) && (cyc <= mRise + 8);
      expVal = mAct && (mRise >= 0) && (cyc >= mRise + 2) && (cyc <= mRise + 9);
      k      = cyc - mRise - 2;
      checkOutput("gnt", 32'(gnt), 32'(expGnt));
      checkOutput("busy", 32'(busy), 32'(actNow));
      checkOutput("trng_en", 32'(trng_en), 32'(expEn));
      checkOutput("err", 32'(err), 32'(expErr));
      checkOutput("trng_rd_en", 32'(trng_rd_en), 32'(expRd));
      checkOutput("dout_valid", 32'(dout_valid), 32'(expVal));
      checkOutput("dout_last", 32'(dout_last), 32'(expVal && k == 7));
      if (expRd) checkOutput("trng_addr", 32'(trng_addr), 32'(k + 1));
      if (expVal) begin
        checkOutput("dout", dout, mWords[3'(k)]);
        checkOutput("dout_id", 32'(dout_id), 32'(mId));
      end
      // advance the model with this cycle's inputs
      idleNow = !actNow;
      if (mAct && mRise < 0 && cyc >= mKick + 1) begin
        if (mSawLow < 0) begin
          if (!trng_rdy) mSawLow = cyc;
        end else if (trng_rdy && cyc <= mKick + TIMEOUT - 1) begin
          mRise = cyc;
          for (int i = 0; i < 8; i++) mWords[3'(i)] = coreWords[3'(i)];
        end
      end
      if (mAct && ((mRise >= 0 && cyc == mRise + 9) || (mRise < 0 && cyc == mKick + TIMEOUT))) mAct = 1'b0;
      if (!mAct && idleNow && (|req) && trng_rdy) begin
        win = mPtr;
        for (int i = N; i >= 1; i--) begin
          idx = (mPtr + i) % N;
          sel = IDW'(idx);
          if (req[sel]) win = idx;
        end
        mAct = 1'b1; mKick = cyc + 1; mId = win; mPtr = win; mRise = -1; mSawLow = -1;
      end
    end
  end

  // Event log of grants, aborts and beats for the directed literal expectations
  int gntLog [$];
  int kickLog [$];
  int errLog [$];
  int beats = 0;
  int lasts = 0;

  always @(negedge clk) begin : monitor
    int g;
    g = -1;
    if (rst_n) begin
      if (trng_en) begin
        for (int i = 0; i < N; i++) if (gnt == (N'(1) << i)) g = i;
        gntLog.push_back(g);
        kickLog.push_back(cyc);
      end
      if (err) errLog.push_back(cyc);
      if (dout_valid) beats++;
      if (dout_valid && dout_last) lasts++;
    end
  end

  task automatic applyStimulus(input logic [N-1:0] r);
    @(posedge clk);
    #1 req = r;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic waitKicks(input int n, input int budget, input string what);
    int t = 0;
    while (kickLog.size() < n && t < budget) begin
      @(negedge clk);
      #1 t++;
    end
    checkOutput(what, 32'(kickLog.size() >= n), 32'd1);
  endtask

  task automatic waitErrs(input int n, input int budget, input string what);
    int t = 0;
    while (errLog.size() < n && t < budget) begin
      @(negedge clk);
      #1 t++;
    end
    checkOutput(what, 32'(errLog.size() >= n), 32'd1);
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic int gntAt(input int i);
    return (i < gntLog.size()) ? gntLog[i] : -1;
  endfunction

  int nK, nB, nL, nE, kickAt, t;
  int exp2 [5] = '{0, 1, 2, 3, 0};
  int exp3 [3] = '{3, 0, 3};

  initial begin
    req      = '0;
    coreMode = 0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single request
    nK = kickLog.size(); nB = beats; nL = lasts;
    applyStimulus(4'b0001);
    waitKicks(nK + 1, 50, "t1_grant_seen");
    checkOutput("t1_gnt_value", 32'(gnt), 32'h1);
    applyStimulus(4'b0000);
    waitCycles(40);
    checkOutput("t1_beats", 32'(beats - nB), 32'd8);
    checkOutput("t1_last_count", 32'(lasts - nL), 32'd1);
    checkOutput("t1_no_err", 32'(errLog.size()), 32'd0);
    checkOutput("t1_kicks", 32'(kickLog.size() - nK), 32'd1);

    // contention from a fresh pointer
    resetDut();
    nK = kickLog.size();
    applyStimulus(4'b1111);
    waitKicks(nK + 5, 400, "t2_grants_seen");
    applyStimulus(4'b0000);
    waitCycles(40);
    for (int i = 0; i < 5; i++) checkOutput("t2_grant_order", 32'(gntAt(nK + i)), 32'(exp2[i]));

    // fairness after wrap
    nK = kickLog.size();
    applyStimulus(4'b1000);
    waitKicks(nK + 1, 100, "t3_grant_a");
    applyStimulus(4'b1001);
    waitKicks(nK + 2, 100, "t3_grant_b");
    applyStimulus(4'b1000);
    waitKicks(nK + 3, 100, "t3_grant_c");
    applyStimulus(4'b0000);
    waitCycles(40);
    for (int i = 0; i < 3; i++) checkOutput("t3_grant_order", 32'(gntAt(nK + i)), 32'(exp3[i]));

    // watchdog abort while rdy stays low
    nK = kickLog.size(); nE = errLog.size();
    coreMode = 1;
    applyStimulus(4'b0100);
    waitKicks(nK + 1, 50, "t4_grant_seen");
    kickAt = kickLog[nK];
    nB = beats;
    applyStimulus(4'b0010);
    waitErrs(nE + 1, 100, "t4_err_seen");
    checkOutput("t4_err_delay", 32'(errLog[errLog.size() - 1] - kickAt), 32'd64);
    checkOutput("t4_gnt_cleared", 32'(gnt), 32'd0);
    checkOutput("t4_no_beats", 32'(beats - nB), 32'd0);
    @(posedge clk);
    #1 coreMode = 0;
    waitKicks(nK + 2, 100, "t4_next_grant");
    applyStimulus(4'b0000);
    waitCycles(40);
    checkOutput("t4_stuck_id", 32'(gntAt(nK)), 32'd2);
    checkOutput("t4_next_id", 32'(gntAt(nK + 1)), 32'd1);
    checkOutput("t4_next_beats", 32'(beats - nB), 32'd8);
    checkOutput("t4_err_once", 32'(errLog.size() - nE), 32'd1);

    // watchdog abort while rdy never drops
    nK = kickLog.size(); nE = errLog.size(); nB = beats;
    coreMode = 2;
    applyStimulus(4'b0001);
    waitKicks(nK + 1, 50, "t5_grant_seen");
    kickAt = kickLog[nK];
    applyStimulus(4'b0000);
    waitErrs(nE + 1, 100, "t5_err_seen");
    checkOutput("t5_err_delay", 32'(errLog[errLog.size() - 1] - kickAt), 32'd64);
    checkOutput("t5_gnt_cleared", 32'(gnt), 32'd0);
    @(posedge clk);
    #1 coreMode = 0;
    waitCycles(5);
    checkOutput("t5_no_beats", 32'(beats - nB), 32'd0);
    checkOutput("t5_err_once", 32'(errLog.size() - nE), 32'd1);

    // reset in the middle of READ
    nK = kickLog.size();
    applyStimulus(4'b0001);
    waitKicks(nK + 1, 50, "t6_grant_seen");
    applyStimulus(4'b0000);
    t = 0;
    while (!(mRise >= 0 && cyc == mRise + 5) && t < 80) begin
      @(negedge clk);
      #1 t++;
    end
    checkOutput("t6_reached_word3", 32'(mRise >= 0 && cyc == mRise + 5), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_gnt", 32'(gnt), 32'd0);
    checkOutput("t6_async_valid", 32'(dout_valid), 32'd0);
    checkOutput("t6_async_busy", 32'(busy), 32'd0);
    checkOutput("t6_async_rd_en", 32'(trng_rd_en), 32'd0);
    checkOutput("t6_async_addr", 32'(trng_addr), 32'd0);
    checkOutput("t6_async_dout", dout, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    nK = kickLog.size(); nB = beats; nL = lasts;
    applyStimulus(4'b0010);
    waitKicks(nK + 1, 50, "t6_new_grant");
    applyStimulus(4'b0000);
    waitCycles(40);
    checkOutput("t6_new_id", 32'(gntAt(nK)), 32'd1);
    checkOutput("t6_new_beats", 32'(beats - nB), 32'd8);
    checkOutput("t6_new_last", 32'(lasts - nL), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
